// File: rtl/axi2apb_pkg.sv
// Shared types and constants for the AXI-to-APB bridge controller.
// Channel structs are sized by the package widths below; the bridge
// parameters are expected to match them.
package axi2apb_pkg;

  localparam int AXI_ADDR_W = 32;
  localparam int AXI_DATA_W = 32;
  localparam int AXI_ID_W   = 4;
  localparam int AXI_STRB_W = AXI_DATA_W / 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WDATA,
    ST_SETUP,
    ST_ACCESS,
    ST_RRESP,
    ST_BRESP
  } state_t;

  typedef struct packed {
    logic [AXI_ID_W-1:0]   id;
    logic [AXI_ADDR_W-1:0] addr;
    logic [7:0]            len;
  } aw_chan_t;

  typedef struct packed {
    logic [AXI_ID_W-1:0]   id;
    logic [AXI_ADDR_W-1:0] addr;
    logic [7:0]            len;
  } ar_chan_t;

  typedef struct packed {
    logic [AXI_DATA_W-1:0] data;
    logic [AXI_STRB_W-1:0] strb;
    logic                  last;
  } w_chan_t;

  typedef struct packed {
    logic [AXI_ID_W-1:0] id;
    logic [1:0]          resp;
  } b_chan_t;

  typedef struct packed {
    logic [AXI_ID_W-1:0]   id;
    logic [AXI_DATA_W-1:0] data;
    logic [1:0]            resp;
    logic                  last;
  } r_chan_t;

endpackage

// File: rtl/axi2apb_ctrl.sv
// AXI-to-APB bridge controller: accepts one AXI burst at a time from
// the AW/W/AR slices, replays it beat by beat as APB transfers and
// returns a single B response or one R beat per APB read.
module axi2apb_ctrl
  import axi2apb_pkg::*;
#(
  parameter int ADDR_WIDTH = AXI_ADDR_W,
  parameter int DATA_WIDTH = AXI_DATA_W,
  parameter int ID_WIDTH   = AXI_ID_W
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    aw_valid_i,
  output logic                    aw_ready_o,
  input  aw_chan_t                aw_data_i,
  input  logic                    w_valid_i,
  output logic                    w_ready_o,
  input  w_chan_t                 w_data_i,
  output logic                    b_valid_o,
  input  logic                    b_ready_i,
  output b_chan_t                 b_data_o,
  input  logic                    ar_valid_i,
  output logic                    ar_ready_o,
  input  ar_chan_t                ar_data_i,
  output logic                    r_valid_o,
  input  logic                    r_ready_i,
  output r_chan_t                 r_data_o,
  output logic [ADDR_WIDTH-1:0]   paddr_o,
  output logic                    psel_o,
  output logic                    penable_o,
  output logic                    pwrite_o,
  output logic [DATA_WIDTH-1:0]   pwdata_o,
  output logic [DATA_WIDTH/8-1:0] pstrb_o,
  input  logic                    pready_i,
  input  logic                    pslverr_i,
  input  logic [DATA_WIDTH-1:0]   prdata_i
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  state_t                  state;
  state_t                  state_nxt;
  logic                    wr_first;   // 1: write wins the next simultaneous request
  logic [ID_WIDTH-1:0]     id_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [7:0]              len_q;
  logic [7:0]              cnt_q;
  logic                    pwrite_q;
  logic [DATA_WIDTH-1:0]   pwdata_q;
  logic [STRB_WIDTH-1:0]   pstrb_q;
  logic                    sticky_q;
  r_chan_t                 r_data_q;
  logic                    grant_wr;
  logic                    grant_rd;
  logic                    beat_last;
  logic                    unused_w_last;

  // Burst address advance; wraps naturally at the top of the address space.
  function automatic logic [ADDR_WIDTH-1:0] next_beat_addr(input logic [ADDR_WIDTH-1:0] a);
    return a + ADDR_WIDTH'(STRB_WIDTH);
  endfunction

  // Beat count is driven by len alone, so the W last flag is not consulted.
  assign unused_w_last = w_data_i.last;
  assign beat_last     = (cnt_q == len_q);

  // Round-robin choice between pending write and read requests.
  always_comb begin
    grant_wr = 1'b0;
    grant_rd = 1'b0;
    if (aw_valid_i && ar_valid_i) begin
      grant_wr = wr_first;
      grant_rd = !wr_first;
    end else begin
      grant_wr = aw_valid_i;
      grant_rd = ar_valid_i;
    end
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state and handshake/APB control decode; everything held low in reset.
  always_comb begin
    state_nxt  = state;
    aw_ready_o = 1'b0;
    ar_ready_o = 1'b0;
    w_ready_o  = 1'b0;
    psel_o     = 1'b0;
    penable_o  = 1'b0;
    b_valid_o  = 1'b0;
    r_valid_o  = 1'b0;
    if (!rst_i) begin
      case (state)
        ST_IDLE: begin
          if (grant_wr) begin
            aw_ready_o = 1'b1;
            state_nxt  = ST_WDATA;
          end else if (grant_rd) begin
            ar_ready_o = 1'b1;
            state_nxt  = ST_SETUP;
          end
        end
        ST_WDATA: begin
          w_ready_o = 1'b1;
          if (w_valid_i) state_nxt = ST_SETUP;
        end
        ST_SETUP: begin
          psel_o    = 1'b1;
          state_nxt = ST_ACCESS;
        end
        ST_ACCESS: begin
          psel_o    = 1'b1;
          penable_o = 1'b1;
          if (pready_i) begin
            if (!pwrite_q)      state_nxt = ST_RRESP;
            else if (beat_last) state_nxt = ST_BRESP;
            else                state_nxt = ST_WDATA;
          end
        end
        ST_RRESP: begin
          r_valid_o = 1'b1;
          if (r_ready_i) state_nxt = r_data_q.last ? ST_IDLE : ST_SETUP;
        end
        ST_BRESP: begin
          b_valid_o = 1'b1;
          if (b_ready_i) state_nxt = ST_IDLE;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // Request latch, beat tracking, APB payload and response capture.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_first <= 1'b1;
      id_q     <= '0;
      addr_q   <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
      pstrb_q  <= '0;
      sticky_q <= 1'b0;
      r_data_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_wr) begin
            id_q     <= aw_data_i.id;
            addr_q   <= aw_data_i.addr;
            len_q    <= aw_data_i.len;
            cnt_q    <= '0;
            pwrite_q <= 1'b1;
            wr_first <= 1'b0;
          end else if (grant_rd) begin
            id_q     <= ar_data_i.id;
            addr_q   <= ar_data_i.addr;
            len_q    <= ar_data_i.len;
            cnt_q    <= '0;
            pwrite_q <= 1'b0;
            pstrb_q  <= '0;
            wr_first <= 1'b1;
          end
        end
        ST_WDATA: begin
          if (w_valid_i) begin
            pwdata_q <= w_data_i.data;
            pstrb_q  <= w_data_i.strb;
          end
        end
        ST_ACCESS: begin
          if (pready_i) begin
            if (pwrite_q) begin
              sticky_q <= sticky_q | pslverr_i;
              if (!beat_last) begin
                cnt_q  <= cnt_q + 8'd1;
                addr_q <= next_beat_addr(addr_q);
              end
            end else begin
              r_data_q.id   <= id_q;
              r_data_q.data <= prdata_i;
              r_data_q.resp <= pslverr_i ? RESP_SLVERR : RESP_OKAY;
              r_data_q.last <= beat_last;
            end
          end
        end
        ST_RRESP: begin
          if (r_ready_i && !r_data_q.last) begin
            cnt_q  <= cnt_q + 8'd1;
            addr_q <= next_beat_addr(addr_q);
          end
        end
        ST_BRESP: begin
          if (b_ready_i) sticky_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign paddr_o  = addr_q;
  assign pwrite_o = pwrite_q;
  assign pwdata_o = pwdata_q;
  assign pstrb_o  = pstrb_q;
  assign r_data_o = r_data_q;
  assign b_data_o = {id_q, (sticky_q ? RESP_SLVERR : RESP_OKAY)};

endmodule

// File: tb/tb_axi2apb_ctrl.sv
// Self-checking bench for axi2apb_ctrl: directed bursts plus randomized
// traffic, every beat checked against expectations computed from the
// burst description (address = base + beat*bytes, per-beat error flags).
module tb_axi2apb_ctrl;
  import axi2apb_pkg::*;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int IW    = 4;
  localparam int BYTES = DW / 8;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic            aw_valid_i, aw_ready_o;
  aw_chan_t        aw_data_i;
  logic            w_valid_i, w_ready_o;
  w_chan_t         w_data_i;
  logic            b_valid_o, b_ready_i;
  b_chan_t         b_data_o;
  logic            ar_valid_i, ar_ready_o;
  ar_chan_t        ar_data_i;
  logic            r_valid_o, r_ready_i;
  r_chan_t         r_data_o;
  logic [AW-1:0]   paddr_o;
  logic            psel_o, penable_o, pwrite_o;
  logic [DW-1:0]   pwdata_o;
  logic [BYTES-1:0] pstrb_o;
  logic            pready_i, pslverr_i;
  logic [DW-1:0]   prdata_i;

  axi2apb_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .aw_valid_i(aw_valid_i), .aw_ready_o(aw_ready_o), .aw_data_i(aw_data_i),
    .w_valid_i(w_valid_i), .w_ready_o(w_ready_o), .w_data_i(w_data_i),
    .b_valid_o(b_valid_o), .b_ready_i(b_ready_i), .b_data_o(b_data_o),
    .ar_valid_i(ar_valid_i), .ar_ready_o(ar_ready_o), .ar_data_i(ar_data_i),
    .r_valid_o(r_valid_o), .r_ready_i(r_ready_i), .r_data_o(r_data_o),
    .paddr_o(paddr_o), .psel_o(psel_o), .penable_o(penable_o), .pwrite_o(pwrite_o),
    .pwdata_o(pwdata_o), .pstrb_o(pstrb_o),
    .pready_i(pready_i), .pslverr_i(pslverr_i), .prdata_i(prdata_i)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;
  bit pref_wr;   // round-robin model: which side wins a simultaneous request

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset;
    rst_i = 1'b1;
    tick;
    tick;
    rst_i   = 1'b0;
    pref_wr = 1'b1;
  endtask

  // One AXI burst driven end to end, with the APB side answered by the bench.
  task automatic run_txn(input bit wr, input bit both, input logic [IW-1:0] t_id,
                         input logic [AW-1:0] t_addr, input logic [7:0] t_len,
                         input int err_beat, input int wmin, input int wmax,
                         input bit fast, input logic [DW-1:0] rd_base);
    int cyc, nw, nd, nw_total;
    bit any_err, e;
    logic [AW-1:0]    a;
    logic [DW-1:0]    wd, rd;
    logic [BYTES-1:0] ws, exp_strb;
    r_chan_t          exp_r;
    b_chan_t          exp_b;
    wd = '0;
    ws = '0;
    aw_data_i  = '{id: t_id, addr: t_addr, len: t_len};
    ar_data_i  = '{id: t_id, addr: t_addr, len: t_len};
    aw_valid_i = wr | both;
    ar_valid_i = !wr | both;
    #1;
    for (int k = 0; k < 8 && !(aw_ready_o || ar_ready_o); k++) tick;
    chk("grant", {aw_ready_o, ar_ready_o}, {wr, !wr});
    if ({aw_ready_o, ar_ready_o} != {wr, !wr}) begin
      aw_valid_i = 1'b0;
      ar_valid_i = 1'b0;
      do_reset;
      return;
    end
    pref_wr = !wr;
    tick;
    aw_valid_i = 1'b0;
    ar_valid_i = 1'b0;
    cyc = 1;
    any_err = 1'b0;
    nw_total = 0;
    for (int i = 0; i <= int'(t_len); i++) begin
      a = t_addr + AW'(i * BYTES);
      if (wr) begin
        nd = fast ? 0 : $urandom_range(2, 0);
        repeat (nd) begin
          #1;
          chk("w_wait", {w_ready_o, psel_o, b_valid_o}, 3'b100);
          tick;
          cyc++;
        end
        wd = $urandom;
        ws = BYTES'($urandom);
        w_data_i  = '{data: wd, strb: ws, last: (i == int'(t_len))};
        w_valid_i = 1'b1;
        #1;
        chk("w_ready", {w_ready_o, psel_o, b_valid_o}, 3'b100);
        tick;
        cyc++;
        w_valid_i = 1'b0;
      end
      exp_strb  = wr ? ws : {BYTES{1'b0}};
      pready_i  = 1'b0;
      #1;
      chk("setup", {psel_o, penable_o, pwrite_o, paddr_o, pstrb_o}, {1'b1, 1'b0, wr, a, exp_strb});
      if (wr) chk("setup_wdata", pwdata_o, wd);
      tick;
      cyc++;
      nw = $urandom_range(wmax, wmin);
      nw_total += nw;
      repeat (nw) begin
        pready_i   = 1'b0;
        pslverr_i  = 1'($urandom);
        prdata_i   = $urandom;
        aw_valid_i = 1'b1;
        ar_valid_i = 1'b1;
        #1;
        chk("access_hold", {psel_o, penable_o, pwrite_o, paddr_o, pstrb_o}, {2'b11, wr, a, exp_strb});
        if (wr) chk("access_wdata", pwdata_o, wd);
        chk("no_axi", {aw_ready_o, ar_ready_o, w_ready_o, r_valid_o, b_valid_o}, 5'b0);
        tick;
        cyc++;
      end
      aw_valid_i = 1'b0;
      ar_valid_i = 1'b0;
      e  = (i == err_beat);
      rd = (rd_base != '0) ? rd_base + DW'(i) : DW'($urandom);
      pready_i  = 1'b1;
      pslverr_i = e;
      prdata_i  = rd;
      #1;
      chk("access", {psel_o, penable_o}, 2'b11);
      tick;
      cyc++;
      pready_i  = 1'b0;
      pslverr_i = 1'b0;
      any_err   = any_err | e;
      if (!wr) begin
        exp_r.id   = t_id;
        exp_r.data = rd;
        exp_r.resp = e ? 2'b10 : 2'b00;
        exp_r.last = (i == int'(t_len));
        if (fast && i == 0 && nw_total == 0) chk("r_latency", cyc, 3);
        nd = fast ? 0 : $urandom_range(2, 0);
        repeat (nd) begin
          r_ready_i = 1'b0;
          #1;
          chk("r_hold", {r_valid_o, psel_o, r_data_o}, {2'b10, exp_r});
          tick;
          cyc++;
        end
        r_ready_i = 1'b1;
        #1;
        chk("r_beat", {r_valid_o, psel_o, r_data_o}, {2'b10, exp_r});
        tick;
        cyc++;
        r_ready_i = 1'b0;
      end
    end
    if (wr) begin
      exp_b.id   = t_id;
      exp_b.resp = any_err ? 2'b10 : 2'b00;
      if (fast && t_len == 8'd0 && nw_total == 0) chk("b_latency", cyc, 4);
      nd = fast ? 0 : $urandom_range(2, 0);
      repeat (nd) begin
        b_ready_i = 1'b0;
        #1;
        chk("b_hold", {b_valid_o, psel_o, b_data_o}, {2'b10, exp_b});
        tick;
        cyc++;
      end
      b_ready_i = 1'b1;
      #1;
      chk("b_resp", {b_valid_o, psel_o, b_data_o}, {2'b10, exp_b});
      tick;
      b_ready_i = 1'b0;
    end
    #1;
    chk("back_idle", {psel_o, penable_o, r_valid_o, b_valid_o, w_ready_o}, 5'b0);
  endtask

  initial begin
    bit rw, bo;
    logic [7:0] ln;
    int eb;
    rst_i = 1'b1;
    aw_valid_i = 0; w_valid_i = 0; ar_valid_i = 0;
    b_ready_i = 0; r_ready_i = 0;
    aw_data_i = '0; w_data_i = '0; ar_data_i = '0;
    pready_i = 0; pslverr_i = 0; prdata_i = '0;
    pref_wr = 1'b1;
    tick;
    tick;

    // Reset state, with requests presented that must not be accepted.
    aw_valid_i = 1'b1; ar_valid_i = 1'b1; w_valid_i = 1'b1;
    #1;
    chk("rst_ctrl", {aw_ready_o, ar_ready_o, w_ready_o, b_valid_o, r_valid_o, psel_o, penable_o}, 7'b0);
    chk("rst_paddr", paddr_o, '0);
    chk("rst_pdata", {pwdata_o, pstrb_o}, '0);
    chk("rst_rdata", r_data_o, '0);
    chk("rst_bdata", b_data_o, '0);
    aw_valid_i = 1'b0; ar_valid_i = 1'b0; w_valid_i = 1'b0;
    rst_i = 1'b0;
    tick;

    // Single read with zero-wait APB; latency and payload.
    run_txn(1'b0, 1'b0, 4'd3, 32'h100, 8'd0, -1, 0, 0, 1'b1, 32'hDEADBEEF);
    // Single write, minimum latency.
    run_txn(1'b1, 1'b0, 4'd5, 32'h40, 8'd0, -1, 0, 0, 1'b1, '0);
    // Four-beat write burst, clean and with an error on one beat.
    run_txn(1'b1, 1'b0, 4'd1, 32'h200, 8'd3, -1, 0, 0, 1'b1, '0);
    run_txn(1'b1, 1'b0, 4'd1, 32'h200, 8'd3, 2, 0, 0, 1'b1, '0);
    // Read burst with an errored middle beat.
    run_txn(1'b0, 1'b0, 4'd7, 32'h480, 8'd2, 1, 0, 0, 1'b1, 32'h1000);
    // Slow peripheral: five wait states per beat.
    run_txn(1'b0, 1'b0, 4'd2, 32'h300, 8'd1, -1, 5, 5, 1'b1, '0);
    run_txn(1'b1, 1'b0, 4'd4, 32'h310, 8'd0, -1, 5, 5, 1'b1, '0);
    // Burst crossing the top of the address space.
    run_txn(1'b1, 1'b0, 4'd9, 32'hFFFF_FFF8, 8'd3, -1, 0, 1, 1'b0, '0);

    // Arbitration from reset: simultaneous requests alternate W, R, W.
    do_reset;
    run_txn(1'b1, 1'b1, 4'd1, 32'h500, 8'd0, -1, 0, 0, 1'b1, '0);
    run_txn(1'b0, 1'b1, 4'd2, 32'h600, 8'd0, -1, 0, 0, 1'b1, '0);
    run_txn(1'b1, 1'b1, 4'd3, 32'h700, 8'd0, -1, 0, 0, 1'b1, '0);

    // Randomized traffic against the round-robin model.
    for (int n = 0; n < 20; n++) begin
      bo = 1'($urandom);
      rw = bo ? pref_wr : 1'($urandom);
      ln = 8'($urandom_range(3, 0));
      eb = ($urandom_range(2, 0) == 0) ? int'($urandom_range(ln, 0)) : -1;
      run_txn(rw, bo, 4'($urandom), {$urandom} & 32'hFFFF_FFFC, ln, eb, 0, 3, 1'b0, '0);
    end

    // Reset during the ACCESS phase of a four-beat read aborts it.
    ar_data_i  = '{id: 4'd6, addr: 32'h800, len: 8'd3};
    ar_valid_i = 1'b1;
    #1;
    chk("abort_grant", ar_ready_o, 1'b1);
    tick;
    ar_valid_i = 1'b0;
    tick;
    pready_i = 1'b0;
    #1;
    chk("abort_in_access", {psel_o, penable_o}, 2'b11);
    rst_i    = 1'b1;
    pready_i = 1'b1;
    tick;
    chk("abort_next", {psel_o, penable_o, r_valid_o, b_valid_o, ar_ready_o, aw_ready_o, w_ready_o}, 7'b0);
    rst_i    = 1'b0;
    pready_i = 1'b0;
    pref_wr  = 1'b1;
    tick;
    chk("abort_idle", {psel_o, penable_o, r_valid_o, b_valid_o}, 4'b0);
    run_txn(1'b0, 1'b0, 4'd8, 32'h900, 8'd1, -1, 0, 0, 1'b1, '0);
    run_txn(1'b1, 1'b1, 4'd2, 32'hA00, 8'd0, -1, 0, 0, 1'b1, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi2apb_ctrl.md
AXI2APB_CTRL -- requirements
Module: axi2apb_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, AXI/APB address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, AXI/APB data width (32 or 64 only).
REQ-003 SHALL have parameter ID_WIDTH, default 4, AXI ID width.
REQ-004 clk_i  in  1  single clock; all logic rising-edge.
REQ-005 rst_i  in  1  reset, synchronous, active-high.
REQ-006 aw_valid_i  in  1  AW slice valid.
REQ-007 aw_ready_o  out  1  AW pop.
REQ-008 aw_data_i  in  aw_chan_t  {id, addr, len[7:0]}.
REQ-009 w_valid_i  in  1  W slice valid.
REQ-010 w_ready_o  out  1  W pop.
REQ-011 w_data_i  in  w_chan_t  {data, strb, last}.
REQ-012 b_valid_o  out  1  B valid toward B slice.
REQ-013 b_ready_i  in  1  B slice ready.
REQ-014 b_data_o  out  b_chan_t  {id, resp[1:0]}.
REQ-015 ar_valid_i  in  1  AR slice valid.
REQ-016 ar_ready_o  out  1  AR pop.
REQ-017 ar_data_i  in  ar_chan_t  {id, addr, len[7:0]}.
REQ-018 r_valid_o  out  1  R valid toward R slice.
REQ-019 r_ready_i  in  1  R slice ready.
REQ-020 r_data_o  out  r_chan_t  {id, data, resp, last}.
REQ-021 paddr_o  out  ADDR_WIDTH  APB address.
REQ-022 psel_o / penable_o / pwrite_o  out  1 each  APB control.
REQ-023 pwdata_o  out  DATA_WIDTH; pstrb_o  out  DATA_WIDTH/8.
REQ-024 pready_i / pslverr_i  in  1 each; prdata_i  in  DATA_WIDTH.

Function
REQ-025 SHALL run FSM IDLE, WDATA, SETUP, ACCESS, RRESP, BRESP.
REQ-026 IDLE: if aw_valid_i or ar_valid_i, grant one request (round-robin; after reset, write is granted first), pulse matching ready for 1 cycle, and latch id/addr/len and beat counter = 0; write -> WDATA, read -> SETUP.
REQ-027 WDATA: w_ready_o=1; on w_valid_i latch data/strb -> SETUP. w_last is ignored; beat count comes from len only.
REQ-028 SETUP: psel=1, penable=0 for exactly 1 cycle -> ACCESS.
REQ-029 ACCESS: psel=1, penable=1; paddr/pwrite/pwdata/pstrb held stable until pready_i=1.
REQ-030 Write beat done: OR pslverr_i into sticky error; if counter==len -> BRESP, else counter+1, addr += DATA_WIDTH/8 (wraps modulo 2^ADDR_WIDTH) -> WDATA.
REQ-031 Read beat done: latch prdata, resp=pslverr?2'b10:2'b00, last=(counter==len) -> RRESP.
REQ-032 RRESP: r_valid_o=1, payload stable until r_ready_i; then last -> IDLE, else counter+1, addr increment -> SETUP.
REQ-033 BRESP: b_valid_o=1, resp = sticky?2'b10:2'b00; on b_ready_i -> IDLE and clear sticky.
REQ-034 At most one AXI transaction in flight; aw/w/ar ready are 0 outside the states named above.
REQ-035 pstrb_o SHALL be 0 for reads; psel_o=0 in IDLE, WDATA, RRESP, BRESP.
REQ-036 Minimum latency: AR accepted cycle 0 -> r_valid_o cycle 3 (pready=1); AW cycle 0, W present -> b_valid_o cycle 4.

Reset
REQ-037 While rst_i=1, state=IDLE; all valid/ready/psel/penable outputs 0; paddr, pwdata, pstrb, r/b payloads 0; sticky error 0; arbiter pointer = write.
REQ-038 Assertion mid-transfer SHALL abort it on the next edge with no further APB or AXI handshakes.

Structure
REQ-039 aw_chan_t, w_chan_t, b_chan_t, ar_chan_t, r_chan_t, state enum and RESP_OKAY/RESP_SLVERR constants SHALL live in package axi2apb_pkg.
REQ-040 Single module; no sub-module (arbiter is one pointer bit).

Verification
REQ-041 AR {id=3, addr=0x100, len=0}, pready=1, prdata=0xDEADBEEF -> r_valid cycle 3, data 0xDEADBEEF, id=3, resp=00, last=1.
REQ-042 AW {id=1, addr=0x200, len=3} + 4 W beats -> paddr 0x200, 0x204, 0x208, 0x20C; one B with id=1, resp=00.
REQ-043 Same burst with pslverr=1 on beat 2 only -> all 4 beats issued, B resp=10.
REQ-044 AW and AR valid together, three times back-to-back -> grants W, R, W.
REQ-045 pready=0 for 5 cycles in ACCESS -> APB signals stable, no AXI handshakes until pready.
REQ-046 rst_i asserted in ACCESS of a len=3 read -> psel=0 and r_valid=0 next cycle, IDLE.
